pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
- Central sequencer for the five pipeline_interface instances (F, D, E, M, W); drives each stage's controller modport: nullify, stall, bubble, keep_exception.
- Resolves load-use hazards, memory wait states, multi-cycle mul/div occupancy and exception flushes with a fixed priority.
- Also produces the PC redirect strobe toward fetch.
- Bit i of every 5-bit control vector targets the pipeline register feeding stage i: 0=F (pc), 1=D, 2=E, 3=M, 4=W.

Parameters:
- MULDIV_CYCLES, 32, execute-stage occupancy of mult/div (≥2).
- MEM_TIMEOUT, 255, wait cycles before a memory access is declared a bus error (≥1).
- CNT_W, 8, width of the internal counters; must hold max(MULDIV_CYCLES, MEM_TIMEOUT).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- d_rs_used  in  1  decode reads rs.
- d_rt_used  in  1  decode reads rt.
- d_rs  in  5  decode rs index.
- d_rt  in  5  decode rt index.
- e_is_load  in  1  execute holds a load.
- e_dest_reg  in  5  execute destination register.
- e_muldiv_start  in  1  execute holds a mult/div this cycle.
- m_mem_req  in  1  memory stage access in progress.
- m_mem_ready  in  1  memory access completes this cycle.
- m_exception  in  1  memory stage commits an exception (from cop0 excdata).
- nullify  out  5  per-stage nullify.
- stall  out  5  per-stage stall.
- bubble  out  5  per-stage bubble.
- keep_exception  out  5  per-stage exception hold.
- redirect  out  1  one-cycle pulse; fetch loads the exception vector.
- bus_error  out  1  one-cycle pulse on memory timeout.
- muldiv_busy  out  1  mul/div counter non-zero.

Behaviour:
- States: RUN, MEM_WAIT, MULDIV, FLUSH. Counters: md_cnt and to_cnt.
- Outputs are combinational from state, counters and same-cycle inputs. State and counters are registered.
- While reset=0: state=FLUSH, md_cnt=0, to_cnt=0, nullify=5'b11111, and all other outputs 0. The first cycle after release is FLUSH, then RUN.
- Priority, highest first: exception/flush > memory wait > mul/div busy > load-use. Exactly one action applies per cycle.
- FLUSH: nullify=5'b01111, keep_exception=5'b10000, redirect=1, stall=bubble=0. Next state is RUN. md_cnt is cleared, aborting any mul/div.
- Exception: m_exception=1 in any state enters FLUSH next cycle. In the detecting cycle, nullify=5'b01111 and stall=0; redirect is not asserted until the FLUSH cycle.
- Memory wait: m_mem_req=1 and m_mem_ready=0 gives stall=5'b01111 and bubble=5'b10000. State=MEM_WAIT; to_cnt increments each cycle.
  - m_mem_ready=1 returns to RUN (or MULDIV if md_cnt≠0) and clears to_cnt.
  - Reaching to_cnt=MEM_TIMEOUT pulses bus_error for one cycle and clears to_cnt. Stalling continues until ready or exception.
- Mul/div: e_muldiv_start=1 in RUN with md_cnt=0 loads md_cnt=MULDIV_CYCLES-1 and enters MULDIV.
  - While md_cnt≠0: stall=5'b00111 and bubble=5'b01000; md_cnt decrements each cycle.
  - md_cnt decrements during MEM_WAIT as well, because the operands are already latched (stall semantics, not bubble).
  - md_cnt reaching 0 returns to RUN. The start cycle itself does not stall.
- Load-use (RUN only, combinational): e_is_load and e_dest_reg≠0 and ((d_rs_used and d_rs==e_dest_reg) or (d_rt_used and d_rt==e_dest_reg)) gives stall=5'b00011 and bubble=5'b00100, for exactly one cycle per occurrence.
- Simultaneous events:
  - Exception together with mem wait: the flush wins, to_cnt clears and bus_error is suppressed.
  - e_muldiv_start while md_cnt≠0: ignored.
  - Load-use during mem wait: masked by the mem-wait stall.
- Invariant: for every bit, stall&bubble=0 and stall&nullify=0.
- Reset asserted mid-operation: immediate return to reset values regardless of state.

Decomposition:
- Shared package pipeline_ctrl_pkg holds:
  - stage index constants STG_F..STG_W;
  - the state enum hz_state_t;
  - control-vector constants CTL_FLUSH, CTL_MEMWAIT_STALL, CTL_MULDIV_STALL, CTL_LOADUSE_STALL.
- Sub-module hazard_loaduse_detect: purely combinational register-compare logic.
- The controller connects to each pipeline_interface.controller modport by bit-slicing its vectors.

Test Plan:
- Reset held 3 cycles, then released → nullify=11111 during reset; first cycle after release redirect=1, nullify=01111; then all outputs 0.
- Load-use: e_is_load=1, e_dest_reg=8, d_rs_used=1, d_rs=8 → stall=00011, bubble=00100 for one cycle. Same stimulus with e_dest_reg=0 → no stall.
- MULDIV_CYCLES=4 with e_muldiv_start pulse → next 3 cycles stall=00111, bubble=01000, muldiv_busy=1; then RUN.
- m_mem_req=1 with ready low for 5 cycles, then high → stall=01111, bubble=10000 for 5 cycles; outputs clear in the ready cycle.
- MEM_TIMEOUT=3 with ready never high → bus_error pulses in cycles 3 and 6; stall persists.
- m_exception during MULDIV with md_cnt=10 → nullify=01111 that cycle; next cycle redirect=1 and keep_exception=10000; muldiv_busy=0 afterwards.

Source files
------------

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared stage indices, state encoding and control-vector constants for the
// pipeline hazard controller.
package pipeline_ctrl_pkg;

  localparam int unsigned NUM_STG = 5;
  localparam int unsigned REG_W   = 5;

  localparam int unsigned STG_F = 0;
  localparam int unsigned STG_D = 1;
  localparam int unsigned STG_E = 2;
  localparam int unsigned STG_M = 3;
  localparam int unsigned STG_W = 4;

  typedef logic [NUM_STG-1:0] ctl_vec_t;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_MEM_WAIT = 2'd1,
    HZ_MULDIV   = 2'd2,
    HZ_FLUSH    = 2'd3
  } hz_state_t;

  typedef struct packed {
    ctl_vec_t nullify;
    ctl_vec_t stall;
    ctl_vec_t bubble;
    ctl_vec_t keep_exception;
    logic     redirect;
    logic     bus_error;
  } hz_ctl_t;

  // Mask covering every stage register from fetch up to and including 'last'.
  function automatic ctl_vec_t upto_mask(input int unsigned last);
    ctl_vec_t m;
    m = '0;
    for (int unsigned i = STG_F; i <= last; i++) m = m | (ctl_vec_t'(1) << i);
    return m;
  endfunction

  function automatic ctl_vec_t stg_bit(input int unsigned stg);
    return ctl_vec_t'(1) << stg;
  endfunction

  localparam ctl_vec_t CTL_ALL             = upto_mask(STG_W);
  localparam ctl_vec_t CTL_FLUSH           = upto_mask(STG_M);
  localparam ctl_vec_t CTL_KEEP_EXC        = stg_bit(STG_W);
  localparam ctl_vec_t CTL_MEMWAIT_STALL   = upto_mask(STG_M);
  localparam ctl_vec_t CTL_MEMWAIT_BUBBLE  = stg_bit(STG_W);
  localparam ctl_vec_t CTL_MULDIV_STALL    = upto_mask(STG_E);
  localparam ctl_vec_t CTL_MULDIV_BUBBLE   = stg_bit(STG_M);
  localparam ctl_vec_t CTL_LOADUSE_STALL   = upto_mask(STG_D);
  localparam ctl_vec_t CTL_LOADUSE_BUBBLE  = stg_bit(STG_E);

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller bundle: stage status inputs and per-stage control vectors.
interface pipeline_hazard_controller_if;
  import pipeline_ctrl_pkg::*;

  logic             d_rs_used;
  logic             d_rt_used;
  logic [REG_W-1:0] d_rs;
  logic [REG_W-1:0] d_rt;
  logic             e_is_load;
  logic [REG_W-1:0] e_dest_reg;
  logic             e_muldiv_start;
  logic             m_mem_req;
  logic             m_mem_ready;
  logic             m_exception;

  ctl_vec_t         nullify;
  ctl_vec_t         stall;
  ctl_vec_t         bubble;
  ctl_vec_t         keep_exception;
  logic             redirect;
  logic             bus_error;
  logic             muldiv_busy;

  modport master (
    output d_rs_used, d_rt_used, d_rs, d_rt, e_is_load, e_dest_reg,
           e_muldiv_start, m_mem_req, m_mem_ready, m_exception,
    input  nullify, stall, bubble, keep_exception, redirect, bus_error, muldiv_busy
  );

  modport slave (
    input  d_rs_used, d_rt_used, d_rs, d_rt, e_is_load, e_dest_reg,
           e_muldiv_start, m_mem_req, m_mem_ready, m_exception,
    output nullify, stall, bubble, keep_exception, redirect, bus_error, muldiv_busy
  );

endinterface

// File: rtl/hazard_loaduse_detect.sv
// Flags a decode-stage source register that depends on a load still in execute.
module hazard_loaduse_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic             d_rs_used,
  input  logic             d_rt_used,
  input  logic [REG_W-1:0] d_rs,
  input  logic [REG_W-1:0] d_rt,
  input  logic             e_is_load,
  input  logic [REG_W-1:0] e_dest_reg,
  output logic             hazard_c
);

  logic rs_hit;
  logic rt_hit;

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  always_comb begin
    rs_hit   = d_rs_used && (d_rs == e_dest_reg);
    rt_hit   = d_rt_used && (d_rt == e_dest_reg);
    hazard_c = e_is_load && (e_dest_reg != '0) && (rs_hit || rt_hit);
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central pipeline sequencer: flush > memory wait > mul/div occupancy > load-use,
// one action per cycle, plus the fetch redirect strobe.
module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MULDIV_CYCLES = 32,
  parameter int unsigned MEM_TIMEOUT   = 255,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  pipeline_hazard_controller_if.slave   bus
);

  localparam logic [1:0] ST_RUN      = HZ_RUN;
  localparam logic [1:0] ST_MEM_WAIT = HZ_MEM_WAIT;
  localparam logic [1:0] ST_MULDIV   = HZ_MULDIV;
  localparam logic [1:0] ST_FLUSH    = HZ_FLUSH;

  localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MULDIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] md_cnt;
  logic [CNT_W-1:0] md_nxt;
  logic [CNT_W-1:0] to_cnt;
  logic [CNT_W-1:0] to_nxt;
  hz_ctl_t          ctl;
  logic             load_use;
  logic             mem_wait;
  logic             md_busy;

  hazard_loaduse_detect u_loaduse (
    .d_rs_used  (bus.d_rs_used),
    .d_rt_used  (bus.d_rt_used),
    .d_rs       (bus.d_rs),
    .d_rt       (bus.d_rt),
    .e_is_load  (bus.e_is_load),
    .e_dest_reg (bus.e_dest_reg),
    .hazard_c   (load_use)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_FLUSH;
      md_cnt <= '0;
      to_cnt <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_nxt;
      to_cnt <= to_nxt;
    end
  end

  always_comb begin
    ctl       = '0;
    state_nxt = ST_RUN;
    md_nxt    = '0;
    to_nxt    = '0;
    mem_wait  = bus.m_mem_req && !bus.m_mem_ready;
    md_busy   = (md_cnt != '0);

    if (!reset) begin
      ctl.nullify = CTL_ALL;
      state_nxt   = ST_FLUSH;
    end else if ((state == ST_FLUSH) || bus.m_exception) begin
      // Counters stay cleared: a pending mul/div and any memory timeout are abandoned.
      ctl.nullify = CTL_FLUSH;
      if (state == ST_FLUSH) begin
        ctl.keep_exception = CTL_KEEP_EXC;
        ctl.redirect       = 1'b1;
      end
      state_nxt = bus.m_exception ? ST_FLUSH : ST_RUN;
    end else begin
      // Operands are already latched, so mul/div keeps counting under any stall.
      if (md_busy) md_nxt = md_cnt - CNT_W'(1);

      if (mem_wait) begin
        ctl.stall  = CTL_MEMWAIT_STALL;
        ctl.bubble = CTL_MEMWAIT_BUBBLE;
        state_nxt  = ST_MEM_WAIT;
        if (to_cnt == TO_LAST) ctl.bus_error = 1'b1;
        else                   to_nxt        = to_cnt + CNT_W'(1);
      end else if (md_busy) begin
        ctl.stall  = CTL_MULDIV_STALL;
        ctl.bubble = CTL_MULDIV_BUBBLE;
        state_nxt  = (md_nxt != '0) ? ST_MULDIV : ST_RUN;
      end else if (bus.e_muldiv_start) begin
        md_nxt    = MD_LOAD;
        state_nxt = ST_MULDIV;
      end else if (load_use) begin
        ctl.stall  = CTL_LOADUSE_STALL;
        ctl.bubble = CTL_LOADUSE_BUBBLE;
      end
    end
  end

  assign bus.nullify        = ctl.nullify;
  assign bus.stall          = ctl.stall;
  assign bus.bubble         = ctl.bubble;
  assign bus.keep_exception = ctl.keep_exception;
  assign bus.redirect       = ctl.redirect;
  assign bus.bus_error      = ctl.bus_error;
  assign bus.muldiv_busy    = md_busy;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller (MULDIV_CYCLES=4, MEM_TIMEOUT=3).
module tb_pipeline_hazard_controller;
  import pipeline_ctrl_pkg::*;

  localparam ctl_vec_t Z = 5'b00000;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller_if hif ();

  pipeline_hazard_controller #(
    .MULDIV_CYCLES (4),
    .MEM_TIMEOUT   (3),
    .CNT_W         (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (hif)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input ctl_vec_t n, s, b, k, input logic r, be, busy);
    check({tag, ".nullify"},        8'(hif.nullify),        8'(n));
    check({tag, ".stall"},          8'(hif.stall),          8'(s));
    check({tag, ".bubble"},         8'(hif.bubble),         8'(b));
    check({tag, ".keep_exception"}, 8'(hif.keep_exception), 8'(k));
    check({tag, ".redirect"},       8'(hif.redirect),       8'(r));
    check({tag, ".bus_error"},      8'(hif.bus_error),      8'(be));
    check({tag, ".muldiv_busy"},    8'(hif.muldiv_busy),    8'(busy));
  endtask

  task automatic idle();
    hif.d_rs_used      = 1'b0;
    hif.d_rt_used      = 1'b0;
    hif.d_rs           = 5'd0;
    hif.d_rt           = 5'd0;
    hif.e_is_load      = 1'b0;
    hif.e_dest_reg     = 5'd0;
    hif.e_muldiv_start = 1'b0;
    hif.m_mem_req      = 1'b0;
    hif.m_mem_ready    = 1'b0;
    hif.m_exception    = 1'b0;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lu_case(input string tag, input logic load, input logic [4:0] dest,
                         input logic rs_u, input logic [4:0] rs,
                         input logic rt_u, input logic [4:0] rt, input logic hit);
    hif.e_is_load  = load;
    hif.e_dest_reg = dest;
    hif.d_rs_used  = rs_u;
    hif.d_rs       = rs;
    hif.d_rt_used  = rt_u;
    hif.d_rt       = rt;
    sample();
    chk(tag, Z, hit ? 5'b00011 : Z, hit ? 5'b00100 : Z, Z, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
  endtask

  // Stall must never overlap bubble or nullify on any stage.
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      assert (((hif.stall & hif.bubble) | (hif.stall & hif.nullify)) === 5'b00000) else begin
        errors++;
        $error("FAIL invariant: observed stall=%b bubble=%b nullify=%b expected no overlap",
               hif.stall, hif.bubble, hif.nullify);
      end
    end
  end

  initial begin
    reset = 1'b0;
    idle();
    for (int i = 0; i < 3; i++) begin
      sample(); chk("reset", 5'b11111, Z, Z, Z, 1'b0, 1'b0, 1'b0); tick();
    end
    reset = 1'b1;
    sample(); chk("flush_after_reset", 5'b01111, Z, Z, 5'b10000, 1'b1, 1'b0, 1'b0); tick();
    sample(); chk("run_idle", Z, Z, Z, Z, 1'b0, 1'b0, 1'b0); tick();

    lu_case("lu_rs",        1'b1, 5'd8, 1'b1, 5'd8, 1'b0, 5'd0, 1'b1);
    sample(); chk("lu_one_cycle", Z, Z, Z, Z, 1'b0, 1'b0, 1'b0); tick();
    lu_case("lu_rt",        1'b1, 5'd8, 1'b0, 5'd0, 1'b1, 5'd8, 1'b1);
    lu_case("lu_unused_rs", 1'b1, 5'd8, 1'b0, 5'd8, 1'b1, 5'd9, 1'b0);
    lu_case("lu_dest_zero", 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    lu_case("lu_not_load",  1'b0, 5'd8, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0);

    // Mul/div: start held high while busy is ignored; a load-use inside is masked.
    hif.e_muldiv_start = 1'b1;
    sample(); chk("md_start", Z, Z, Z, Z, 1'b0, 1'b0, 1'b0); tick();
    for (int i = 1; i <= 3; i++) begin
      hif.e_is_load  = (i == 2);
      hif.e_dest_reg = 5'd8;
      hif.d_rs_used  = 1'b1;
      hif.d_rs       = 5'd8;
      sample(); chk("md_busy", Z, 5'b00111, 5'b01000, Z, 1'b0, 1'b0, 1'b1); tick();
    end
    idle();
    sample(); chk("md_done", Z, Z, Z, Z, 1'b0, 1'b0, 1'b0); tick();

    // Memory wait of five cycles, with a masked load-use, then ready.
    hif.m_mem_req = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      hif.e_is_load  = (i == 2);
      hif.e_dest_reg = 5'd8;
      hif.d_rs_used  = 1'b1;
      hif.d_rs       = 5'd8;
      sample(); chk("mw", Z, 5'b01111, 5'b10000, Z, 1'b0, (i == 3), 1'b0); tick();
    end
    hif.e_is_load   = 1'b0;
    hif.m_mem_ready = 1'b1;
    sample(); chk("mw_ready", Z, Z, Z, Z, 1'b0, 1'b0, 1'b0); tick();

    // Ready never arrives: timeout pulses every third cycle.
    hif.m_mem_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      sample(); chk("mw_timeout", Z, 5'b01111, 5'b10000, Z, 1'b0, (i == 3 || i == 6), 1'b0); tick();
    end
    hif.m_exception = 1'b1;
    sample(); chk("mw_exc", 5'b01111, Z, Z, Z, 1'b0, 1'b0, 1'b0); tick();
    idle();
    sample(); chk("mw_exc_flush", 5'b01111, Z, Z, 5'b10000, 1'b1, 1'b0, 1'b0); tick();
    sample(); chk("mw_exc_run", Z, Z, Z, Z, 1'b0, 1'b0, 1'b0); tick();

    // Mul/div keeps counting through a memory wait and resumes its stall on ready.
    hif.e_muldiv_start = 1'b1;
    sample(); chk("mdmw_start", Z, Z, Z, Z, 1'b0, 1'b0, 1'b0); tick();
    hif.e_muldiv_start = 1'b0;
    hif.m_mem_req      = 1'b1;
    sample(); chk("mdmw_wait", Z, 5'b01111, 5'b10000, Z, 1'b0, 1'b0, 1'b1); tick();
    hif.m_mem_ready = 1'b1;
    sample(); chk("mdmw_ready", Z, 5'b00111, 5'b01000, Z, 1'b0, 1'b0, 1'b1); tick();
    idle();
    sample(); chk("mdmw_last", Z, 5'b00111, 5'b01000, Z, 1'b0, 1'b0, 1'b1); tick();
    sample(); chk("mdmw_done", Z, Z, Z, Z, 1'b0, 1'b0, 1'b0); tick();

    // Exception while mul/div is busy aborts it.
    hif.e_muldiv_start = 1'b1;
    sample(); tick();
    hif.e_muldiv_start = 1'b0;
    sample(); chk("mdexc_busy", Z, 5'b00111, 5'b01000, Z, 1'b0, 1'b0, 1'b1); tick();
    hif.m_exception = 1'b1;
    sample(); chk("mdexc_detect", 5'b01111, Z, Z, Z, 1'b0, 1'b0, 1'b1); tick();
    hif.m_exception = 1'b0;
    sample(); chk("mdexc_flush", 5'b01111, Z, Z, 5'b10000, 1'b1, 1'b0, 1'b0); tick();
    sample(); chk("mdexc_run", Z, Z, Z, Z, 1'b0, 1'b0, 1'b0); tick();

    // Asynchronous reset in the middle of a mul/div.
    hif.e_muldiv_start = 1'b1;
    sample(); tick();
    hif.e_muldiv_start = 1'b0;
    #2 reset = 1'b0;
    sample(); chk("async_reset", 5'b11111, Z, Z, Z, 1'b0, 1'b0, 1'b0); tick();
    reset = 1'b1;
    sample(); chk("async_flush", 5'b01111, Z, Z, 5'b10000, 1'b1, 1'b0, 1'b0); tick();
    sample(); chk("async_run", Z, Z, Z, Z, 1'b0, 1'b0, 1'b0); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
